calc_seq: RTL
=============

# calc_seq

Command sequencer placed directly upstream of the `calc` token calculator. It accepts whole commands (`op`, `a`, `b`) over a valid/ready interface and buffers them in a small FIFO. It serializes each command into the `validIn`/`dataIn` token stream that `calc` expects, then captures `calc`'s `dataOut` in the cycle the result settles. The captured result is returned on a valid/ready result port, so the rest of the design never deals with token ordering.

## Interface
- `DATA_W`, 16: operand/result width; must match `calc`.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. Must be the same reset that drives `calc`.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 2: 0=MUL, 1=ADD, 2=SQR, 3=INC.
- `cmd_a` in DATA_W: first operand.
- `cmd_b` in DATA_W: second operand; ignored for SQR/INC.
- `calc_valid` out 1: to `calc.validIn`.
- `calc_data` out DATA_W: to `calc.dataIn`.
- `calc_result` in DATA_W: from `calc.dataOut`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_data` out DATA_W: result.

## Operation
- Command push occurs on `cmd_valid & cmd_ready`. `cmd_ready = !full`, decoded from registered count.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Push and pop in the same cycle leave the count unchanged. Pop only when non-empty.
- FSM states: IDLE, SEND_A, SEND_OP, SEND_B, CAPTURE, HOLD.
  - IDLE: if FIFO non-empty, pop into the command register, go to SEND_A.
  - SEND_A: `calc_valid=1`, `calc_data=a`; go to SEND_OP.
  - SEND_OP: `calc_valid=1`, `calc_data` = zero-extended `op`. Go to SEND_B if op is MUL or ADD, else CAPTURE.
  - SEND_B: `calc_valid=1`, `calc_data=b`; go to CAPTURE.
  - CAPTURE: `calc_valid=0`. Register `res_data <= calc_result`, `res_valid <= 1`; go to HOLD.
  - HOLD: hold `res_data`/`res_valid` stable. On `res_ready`, clear `res_valid` and go to IDLE.
- `calc_valid` and `calc_data` are decoded from registered state and the command register only. There is no combinational path from any input.
- `calc_valid=0` in IDLE, CAPTURE and HOLD. `calc_data=0` whenever `calc_valid=0`.
- The opcode token is always in the range 0..3, so `calc`'s error/re-arm path is never exercised.
- Results are `calc`'s values unchanged: MUL and SQR keep the low DATA_W bits of the product; ADD and INC wrap modulo 2^DATA_W.
- One command is in flight at a time. `calc` is never given a new token before the previous result is captured.

## Timing
- Reset values: `cmd_ready=1` (FIFO empty), `calc_valid=0`, `calc_data=0`, `res_valid=0`, `res_data=0`, FSM=IDLE.
- Latency, command push (edge 0) to `res_valid` high:
  - MUL/ADD: cycle 6 (IDLE 1, A 2, OP 3, B 4, CAPTURE 5).
  - SQR/INC: cycle 5.
- `calc` updates `dataOut` on the edge that samples the last token. CAPTURE is exactly the next cycle.
- Reset mid-operation: FIFO emptied, FSM to IDLE, any pending result dropped. `calc` resets on the same edge, so token alignment is preserved.
- FIFO full: `cmd_ready=0`, `cmd_valid` ignored, no overwrite.
- `res_ready` held high: one result per command, with no loss.

## Configuration
- `CALC_SEQ_B2B_EN`
  - Defined: in HOLD, if `res_ready` and the FIFO is non-empty, pop and go straight to SEND_A, skipping IDLE. Sustained throughput is 1 command per 5 cycles (MUL/ADD) or 4 cycles (SQR/INC).
  - Undefined: HOLD always returns to IDLE (+1 cycle per command).
- Latency of the first command is identical in both builds.

## Structure
- `calc_pkg` contains:
  - `calc_op_e` enum (MUL=0, ADD=1, SQR=2, INC=3).
  - `calc_cmd_t` packed struct {op, a, b}.
  - `calc_seq_state_e`.
  - `CALC_DATA_W` = 16.
- Sub-module `calc_seq_fifo`: synchronous FIFO of `calc_cmd_t`, with ports push/pop/full/empty and a registered count.
- The FSM and result register live in `calc_seq`.

## Test plan
- MUL a=3, b=5 with `res_ready=1` → `res_data=15`; `res_valid` in cycle 6 after push; tokens 3, 0, 5 seen on consecutive cycles.
- ADD a=0xFFFF, b=2 → 0x0001. INC a=7 → 8, `res_valid` in cycle 5, only 2 tokens issued.
- SQR a=0x0100 → 0x0000, low-16 truncation; SQR a=0x00FF → 0xFE01.
- `res_ready=0` while 5 commands are pushed with `FIFO_DEPTH=4`:
  - `cmd_ready` drops after the 4th queued command (one is also held in the sequencer).
  - Results then drain in order once `res_ready=1`.
- Assert `rst` during SEND_B of a MUL → the next cycle shows `calc_valid=0`, `res_valid=0`, `cmd_ready=1`. A following INC a=1 returns 2.
- With `CALC_SEQ_B2B_EN`, push 3 INC back-to-back with `res_ready=1` → results are 4 cycles apart; without the macro they are 5 cycles apart.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calc command sequencer: opcodes, queued command, FSM states.
package calc_pkg;

    localparam int CALC_DATA_W = 16;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SQR = 2'd2,
        OP_INC = 2'd3
    } calc_op_e;

    typedef struct packed {
        calc_op_e               op;
        logic [CALC_DATA_W-1:0] a;
        logic [CALC_DATA_W-1:0] b;
    } calc_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_OP,
        S_SEND_B,
        S_CAPTURE,
        S_HOLD
    } calc_seq_state_e;

    // Only the two-operand ops send a third token.
    function automatic logic op_has_b(calc_op_e op);
        return (op == OP_MUL) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/calc_seq_fifo.sv
// Synchronous command FIFO; pop data is presented from the head slot (show-ahead).
module calc_seq_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  calc_cmd_t wr_data,
    input  logic      pop,
    output calc_cmd_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    calc_cmd_t        mem_q [DEPTH];
    calc_cmd_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/calc_seq.sv
// Serializes queued (op, a, b) commands into calc's token stream and returns its result.
// Optional CALC_SEQ_B2B_EN: HOLD pops the next command directly, skipping IDLE.
module calc_seq
    import calc_pkg::*;
#(
    parameter int DATA_W     = CALC_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              calc_valid,
    output logic [DATA_W-1:0] calc_data,
    input  logic [DATA_W-1:0] calc_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data
);

    calc_seq_state_e   state_q, state_d;
    calc_cmd_t         cmd_q, cmd_d;
    calc_cmd_t         fifo_wr, fifo_rd;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              fifo_pop, fifo_full, fifo_empty;

    assign fifo_wr.op = calc_op_e'(cmd_op);
    assign fifo_wr.a  = cmd_a;
    assign fifo_wr.b  = cmd_b;
    assign cmd_ready  = ~fifo_full;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

    calc_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Token outputs depend only on state_q/cmd_q, never on an input.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        fifo_pop    = 1'b0;
        calc_valid  = 1'b0;
        calc_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rd;
                    state_d  = S_SEND_A;
                end
            end
            S_SEND_A: begin
                calc_valid = 1'b1;
                calc_data  = cmd_q.a;
                state_d    = S_SEND_OP;
            end
            S_SEND_OP: begin
                calc_valid = 1'b1;
                calc_data  = DATA_W'(cmd_q.op);
                state_d    = op_has_b(cmd_q.op) ? S_SEND_B : S_CAPTURE;
            end
            S_SEND_B: begin
                calc_valid = 1'b1;
                calc_data  = cmd_q.b;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_data_d  = calc_result;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef CALC_SEQ_B2B_EN
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cmd_d    = fifo_rd;
                        state_d  = S_SEND_A;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule
